vedic_pp_accum64: RTL



---
 rtl/vedic_pkg.sv | 31 +++
 rtl/vedic_pp_accum64_if.sv | 31 +++
 rtl/add32c.sv | 25 ++
 rtl/fa.sv | 22 ++
 rtl/ha.sv | 15 +
 rtl/vedic_pp_accum64.sv | 130 +++++++++++++
 6 files changed

// File: rtl/vedic_pkg.sv
// -----------------------------------------------------------------------------
// vedic_pkg
// Shared types and constants for the 32x32 Vedic multiplier datapath.
//   - state_e   : combiner FSM states (IDLE / ACC / DONE)
//   - BEATS     : partial products per 32x32 multiply (LL, LH, HL, HH)
//   - SHIFT_TAB : left shift applied to beat k before accumulation
//   - beat_operand() : zero-extend a beat to product width and shift it
// -----------------------------------------------------------------------------
package vedic_pkg;

  localparam int PP_W   = 32;
  localparam int PROD_W = 64;
  localparam int BEATS  = 4;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Element k is the shift for beat k: LL=0, LH=16, HL=16, HH=32.
  localparam logic [BEATS-1:0][5:0] SHIFT_TAB = {6'd32, 6'd16, 6'd16, 6'd0};

  function automatic logic [PROD_W-1:0] beat_operand(input logic [PP_W-1:0] data,
                                                      input beat_idx_t     k);
    return {{(PROD_W-PP_W){1'b0}}, data} << SHIFT_TAB[k];
  endfunction

endpackage

// File: rtl/vedic_pp_accum64_if.sv
// -----------------------------------------------------------------------------
// vedic_pp_accum64_if
// Bundles the partial-product input stream and the product output stream.
//   pp_valid/pp_ready/pp_sop/pp_data : 32-bit partial-product beats (LL first)
//   prod_valid/prod_ready/prod       : 64-bit product, held until consumed
//   sync_err                         : one-cycle resync/discard pulse
// Modports: master = producer/consumer side, slave = the combiner.
// -----------------------------------------------------------------------------
interface vedic_pp_accum64_if;
  import vedic_pkg::*;

  logic              pp_valid;
  logic              pp_ready;
  logic              pp_sop;
  logic [PP_W-1:0]   pp_data;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              sync_err;

  modport master (
    output pp_valid, pp_sop, pp_data, prod_ready,
    input  pp_ready, prod_valid, prod, sync_err
  );

  modport slave (
    input  pp_valid, pp_sop, pp_data, prod_ready,
    output pp_ready, prod_valid, prod, sync_err
  );

endinterface

// File: rtl/add32c.sv
// -----------------------------------------------------------------------------
// add32c : 32-bit ripple-carry adder with carry in and carry out.
//   a, b : 32-bit addends    cin : carry in
//   s    : 32-bit sum        cout: carry out of bit 31
// Two of these chained by carry form the 64-bit accumulate adder.
// -----------------------------------------------------------------------------
module add32c (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [32:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign cout = c[32];

endmodule

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa : full-adder cell built from two half adders.
//   a, b, ci : addend bits and carry in    s : sum    co : carry out
// -----------------------------------------------------------------------------
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/ha.sv
// -----------------------------------------------------------------------------
// ha : half-adder cell.
//   a, b : addend bits    s : sum    c : carry
// -----------------------------------------------------------------------------
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/vedic_pp_accum64.sv
// -----------------------------------------------------------------------------
// vedic_pp_accum64
// Collects the four 32-bit partial products of one 32x32 Vedic multiply
// (LL, LH, HL, HH), shifts each by {0,16,16,32} and accumulates them into a
// 64-bit product, which is then held on the output until consumed.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : vedic_pp_accum64_if.slave (beat stream in, product stream out,
//           sync_err pulse)
// A beat with pp_sop in the middle of a group restarts the group from that
// beat; a beat without pp_sop while idle is dropped. Both raise sync_err.
// -----------------------------------------------------------------------------
module vedic_pp_accum64
  import vedic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  vedic_pp_accum64_if.slave     bus
);

  state_e            state_q, state_d;
  beat_idx_t         k_q, k_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic              sync_err_q, sync_err_d;

  logic              accept;
  logic [PROD_W-1:0] operand;
  logic [PROD_W-1:0] sum;
  logic              lo_cout;
  logic              hi_cout_unused;

  assign accept  = bus.pp_valid && (state_q != DONE);
  assign operand = beat_operand(bus.pp_data, k_q);

  // 64-bit accumulate as two carry-chained 32-bit halves. The final carry is
  // dropped: legal partial products can never overflow 64 bits.
  add32c u_add_lo (
    .a    (acc_q[31:0]),
    .b    (operand[31:0]),
    .cin  (1'b0),
    .s    (sum[31:0]),
    .cout (lo_cout)
  );

  add32c u_add_hi (
    .a    (acc_q[63:32]),
    .b    (operand[63:32]),
    .cin  (lo_cout),
    .s    (sum[63:32]),
    .cout (hi_cout_unused)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    sync_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.pp_sop) begin
            acc_d   = {{(PROD_W-PP_W){1'b0}}, bus.pp_data};
            k_d     = beat_idx_t'(1);
            state_d = ACC;
          end else begin
            // Stray beat with no group open: drop it.
            sync_err_d = 1'b1;
          end
        end
      end

      ACC: begin
        if (accept) begin
          if (bus.pp_sop) begin
            // Early start-of-group: abandon the partial sum, this beat is LL.
            acc_d      = {{(PROD_W-PP_W){1'b0}}, bus.pp_data};
            k_d        = beat_idx_t'(1);
            sync_err_d = 1'b1;
          end else begin
            acc_d = sum;
            if (k_q == beat_idx_t'(BEATS-1)) begin
              k_d     = '0;
              state_d = DONE;
            end else begin
              k_d = k_q + beat_idx_t'(1);
            end
          end
        end
      end

      DONE: begin
        if (bus.prod_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the accumulator is reset as well because it drives prod directly
      // and prod must read zero out of reset.
      state_q    <= IDLE;
      k_q        <= '0;
      acc_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.pp_ready   = (state_q != DONE);
  assign bus.prod_valid = (state_q == DONE);
  assign bus.prod       = acc_q;
  assign bus.sync_err   = sync_err_q;

endmodule
